// File: rtl/mult_pipe2_arb.sv
// rtl/mult_pipe2_arb.sv - round-robin arbiter and sequencer sharing one pipelined multiplier
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   en             issue enable; low blocks new grants, in-flight work still completes
//   req_valid      per-requester operand-pair valid
//   req_ready      one-hot-or-zero grant, combinational
//   req_a, req_b   packed per-requester operands, requester i at [i*SIZE +: SIZE]
//   mul_a, mul_b   registered operands to the shared multiplier
//   mul_pdt        product returned by the multiplier, LVL cycles after its operands
//   rsp_valid      one-cycle pulse to the requester that owns rsp_pdt
//   rsp_pdt        product, zero when no response is emitted
//   inflight       accepted operations not yet returned
//   busy           inflight != 0
module mult_pipe2_arb #(
    parameter int SIZE = 16,
    parameter int LVL  = 2,
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*SIZE-1:0]     req_a,
    input  logic [NREQ*SIZE-1:0]     req_b,
    output logic [SIZE-1:0]          mul_a,
    output logic [SIZE-1:0]          mul_b,
    input  logic [2*SIZE-1:0]        mul_pdt,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [2*SIZE-1:0]        rsp_pdt,
    output logic [$clog2(LVL+2)-1:0] inflight,
    output logic                     busy
);

    localparam int PW = $clog2(NREQ);
    localparam int IW = $clog2(LVL + 2);

    logic [PW-1:0] ptr;
    logic          grant_found;
    logic [PW-1:0] grant_idx;
    logic [PW:0]   scan_idx;

    logic          iss_valid;
    logic [PW-1:0] iss_tag;

    logic          tag_valid [LVL];
    logic [PW-1:0] tag_pipe  [LVL];

    logic          rsp_fire;

    // Scan requesters starting at ptr and wrapping; the first valid one wins.
    // ptr + k is always below 2*NREQ, so one conditional subtract is a full modulo.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        req_ready   = '0;
        scan_idx    = '0;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = {1'b0, ptr} + (PW+1)'(k);
                if (scan_idx >= (PW+1)'(NREQ)) begin
                    scan_idx = scan_idx - (PW+1)'(NREQ);
                end
                if (!grant_found && req_valid[scan_idx[PW-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx[PW-1:0];
                end
            end
            if (grant_found) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    // Issue stage: operands go to zero on idle cycles so the multiplier inputs
    // are deterministic even though its output is masked by the valid pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            iss_valid <= 1'b0;
            iss_tag   <= '0;
        end else begin
            if (grant_found) begin
                ptr       <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
                mul_a     <= req_a[grant_idx*SIZE +: SIZE];
                mul_b     <= req_b[grant_idx*SIZE +: SIZE];
                iss_valid <= 1'b1;
                iss_tag   <= grant_idx;
            end else begin
                mul_a     <= '0;
                mul_b     <= '0;
                iss_valid <= 1'b0;
            end
        end
    end

    // Tag pipe mirrors the multiplier's LVL register stages; it never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LVL; i++) begin
                tag_valid[i] <= 1'b0;
                tag_pipe[i]  <= '0;
            end
        end else begin
            tag_valid[0] <= iss_valid;
            tag_pipe[0]  <= iss_tag;
            for (int i = 1; i < LVL; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_pipe[i]  <= tag_pipe[i-1];
            end
        end
    end

    assign rsp_fire = tag_valid[LVL-1];

    always_comb begin
        rsp_valid = '0;
        rsp_pdt   = '0;
        if (rsp_fire) begin
            rsp_valid[tag_pipe[LVL-1]] = 1'b1;
            rsp_pdt                    = mul_pdt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({grant_found, rsp_fire})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy = (inflight != '0);

endmodule

// File: doc/mult_pipe2_arb.md
Name: mult_pipe2_arb

Overview:
Round-robin arbiter and sequencer that shares one pipelined multiplier (mult_pipe2, SIZE-bit operands, LVL register stages, no reset, no stall) between NREQ requesters.
- Accepts at most one operand pair per cycle via valid/ready and drives the multiplier operand ports from a registered issue stage.
- Carries a requester tag and valid bit alongside the multiplier pipeline, and returns each product to its originating requester as a one-cycle pulse.
- Sits between the accelerator's MAC-issuing units and the shared multiplier instance.

Parameters:
SIZE, 16, operand width; product width is 2*SIZE
LVL, 2, multiplier latency: operands presented in cycle t produce mul_pdt in cycle t+LVL; must be >= 1
NREQ, 4, number of requesters; must be >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  issue enable; 0 blocks new grants, in-flight operations still complete
req_valid  in  NREQ  requester i has an operand pair
req_ready  out  NREQ  one-hot-or-zero grant; combinational from req_valid, en and the priority pointer
req_a  in  NREQ*SIZE  requester i operand a at bits [i*SIZE +: SIZE]
req_b  in  NREQ*SIZE  requester i operand b, same packing
mul_a  out  SIZE  to multiplier a, registered
mul_b  out  SIZE  to multiplier b, registered
mul_pdt  in  2*SIZE  from multiplier pdt
rsp_valid  out  NREQ  one-cycle pulse to the originating requester
rsp_pdt  out  2*SIZE  product; meaningful only when some rsp_valid bit is 1
inflight  out  $clog2(LVL+2)  count of accepted, not yet returned operations
busy  out  1  inflight != 0

Behaviour:
- Arbitration (combinational):
  - Priority pointer ptr (reset 0). If en=1 and any req_valid is set, grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., NREQ-1, 0, ... cyclically.
  - req_ready = that single one-hot bit. req_ready = 0 when en=0 or no request is valid.
  - A handshake occurs when req_valid[i] & req_ready[i]. At most one handshake per cycle.
  - On a handshake with index g, ptr <= (g+1) mod NREQ at the clock edge. Otherwise ptr holds.
- Issue stage, at the edge ending the handshake cycle c:
  - mul_a, mul_b load req_a[g], req_b[g].
  - Issue valid <= 1, issue tag <= g.
  - With no handshake: mul_a, mul_b <= 0 and issue valid <= 0.
- Tag pipeline:
  - LVL-deep shift register of {valid, tag}, fed from the issue stage every cycle, unconditionally (the multiplier never stalls).
- Response, combinational from the last tag stage:
  - rsp_valid[tag] = 1 in cycle c+1+LVL; all other bits 0.
  - rsp_pdt = mul_pdt when any rsp_valid bit is set; rsp_pdt = 0 otherwise.
  - Fixed handshake-to-response latency of LVL+1 cycles (3 with defaults).
  - Throughput: 1 operation per cycle; back-to-back results appear in acceptance order.
- inflight:
  - Increments on a handshake; decrements when a response is emitted.
  - Both in the same cycle leaves it unchanged.
  - Maximum value is LVL+1, so it never overflows.
- Requester rules:
  - Requesters must hold req_valid and operands stable until accepted.
  - The arbiter does not check this. Dropping req_valid before grant simply withdraws the request.
- en deasserted mid-stream: no new grants. Already-accepted operations return on schedule. ptr holds.
- Reset, asynchronous, any time:
  - ptr=0, mul_a=mul_b=0, all issue and tag-pipe valids 0, inflight=0, busy=0, rsp_valid=0, rsp_pdt=0.
  - Operations in flight at reset are discarded; no rsp_valid is ever produced for them.
  - Because the multiplier has no reset, mul_pdt garbage during and after reset is masked by the valid pipe.
- Arithmetic: unsigned, full 2*SIZE-bit product, no truncation. The arbiter passes mul_pdt through unmodified.

Test Plan:
1. Single request: after reset, requester 2 presents a=3, b=5 with en=1. Require req_ready=0100 in that cycle, mul_a=3 and mul_b=5 one cycle later, then rsp_valid=0100 with rsp_pdt=15 exactly 3 cycles after the handshake. inflight goes 0->1->0, busy pulses for 3 cycles.
2. Round-robin fairness: all four requesters hold valid continuously with a=i+1, b=16'h0100. Require grants 0,1,2,3,0,1,... one per cycle and responses 16'h0100, 16'h0200, 16'h0300, 16'h0400 to requesters 0-3 in the same order, with a steady-state inflight of 3.
3. Pointer skip and wrap: ptr=3 after granting requester 2, with only requesters 1 and 3 valid. Require grant 3, then 1 (wrap-around), then ptr=2.
4. Boundary values: a=b=16'hFFFF. Require rsp_pdt=32'hFFFE0001. With a=0, b=16'hFFFF, require rsp_pdt=0 with rsp_valid still pulsed.
5. en gating: assert en=0 for 4 cycles while requests are pending, with 2 operations already in flight. Require req_ready=0 throughout, both responses still return on schedule, and inflight drains to 0. On en=1 the grant resumes at ptr.
6. Reset mid-operation: issue 3 back-to-back operations, then pulse rst for 1 cycle, asynchronously, before any response. Require no rsp_valid for any of them, inflight=0, and ptr=0. A new request after reset returns correctly with latency 3.
